// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: SPI mode-3 master that repeatedly reads a 16-bit ADC word.
// A channel command goes out MSB first on adc_mosi while the reply is shifted in.
// One shared down-counter times every FSM state.
// Every output is driven from a flop.
module adc_spi_sampler #(
  parameter int CLK_DIV   = 4,
  parameter int GAP       = 8,
  parameter int FLAG_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  ch,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  output logic [15:0] ADC_data,
  output logic        flag,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

  localparam logic [7:0] DIV_LOAD  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);
  localparam logic [7:0] FLAG_LOAD = 8'(FLAG_HOLD - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        hi_q, hi_d;
  logic [3:0]  chLat_q, chLat_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] data_q, data_d;
  logic        csN_q, csN_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        flag_q, flag_d;
  logic        busy_q, busy_d;
  logic [15:0] cmd;

  assign cmd = {2'b00, chLat_q, 10'b0};

  // Next-state, counter reload and registered-output decode for the whole frame sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    chLat_d = chLat_q;
    rx_d    = rx_q;
    data_d  = data_q;
    mosi_d  = mosi_q;

    if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (cnt_q == 8'd0 && enable) begin
          state_d = SETUP;
          cnt_d   = DIV_LOAD;
          chLat_d = ch;
          // The command MSB is a fixed zero, whatever the channel
          mosi_d  = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = SHIFT;
          cnt_d   = DIV_LOAD;
          bit_d   = 4'd0;
          hi_d    = 1'b0;
          mosi_d  = cmd[15];
        end
      end
      SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d = DIV_LOAD;
          if (!hi_q) begin
            hi_d = 1'b1;
            rx_d = {rx_q[14:0], adc_miso};
          end else if (bit_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            hi_d   = 1'b0;
            bit_d  = bit_q + 4'd1;
            mosi_d = cmd[4'd15 - bit_d];
          end
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          cnt_d   = FLAG_LOAD;
          data_d  = rx_q;
        end
      end
      DONE: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = GAP_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = GAP_LOAD;
      end
    endcase

    csN_d  = (state_d == IDLE) || (state_d == DONE);
    sclk_d = !((state_d == SHIFT) && !hi_d);
    flag_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State, counter, shift and output registers; reset aborts any frame in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= GAP_LOAD;
      bit_q   <= 4'd0;
      hi_q    <= 1'b0;
      chLat_q <= 4'd0;
      rx_q    <= 16'h0000;
      data_q  <= 16'h0000;
      csN_q   <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      chLat_q <= chLat_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      csN_q   <= csN_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
    end
  end

  assign adc_cs_n = csN_q;
  assign adc_sclk = sclk_q;
  assign adc_mosi = mosi_q;
  assign ADC_data = data_q;
  assign flag     = flag_q;
  assign busy     = busy_q;

endmodule

// File: doc/adc_spi_sampler.md
ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period, legal range 2..255.
REQ-002 Parameter GAP, default 8: clk cycles with cs_n high between frames, legal range 1..255.
REQ-003 Parameter FLAG_HOLD, default 4: clk cycles flag stays high after a frame, legal range 1..255.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: system clock, rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port enable, input, 1 bit: 1 allows a new frame to start.
REQ-008 Port ch, input, 4 bits: channel address for the next conversion.
REQ-009 Port adc_miso, input, 1 bit: serial data from the ADC.
REQ-010 Port adc_cs_n, output, 1 bit: ADC chip select, active low.
REQ-011 Port adc_sclk, output, 1 bit: serial clock, idles high (SPI mode 3).
REQ-012 Port adc_mosi, output, 1 bit: serial command to the ADC.
REQ-013 Port ADC_data, output, 16 bits: last completed conversion word.
REQ-014 Port flag, output, 1 bit: high for FLAG_HOLD cycles after ADC_data updates.
REQ-015 Port busy, output, 1 bit: high in SETUP, SHIFT, HOLD and DONE.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and DONE, and one shared down-counter SHALL time every state.
REQ-017 IDLE: adc_cs_n=1 and adc_sclk=1; after GAP cycles, if enable=1, the FSM SHALL latch ch into ch_lat and go to SETUP; otherwise it SHALL stay in IDLE and re-check every cycle.
REQ-018 Command word: cmd = {2'b00, ch_lat, 10'b0}, sent MSB first.
REQ-019 SETUP: adc_cs_n=0, adc_sclk=1 and adc_mosi=cmd[15] for CLK_DIV cycles, then the FSM SHALL go to SHIFT.
REQ-020 SHIFT: for each of 16 bits, adc_sclk SHALL be low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-021 adc_mosi SHALL change only when adc_sclk falls, presenting cmd[15-k] during bit k (k = 0..15).
REQ-022 adc_miso SHALL be shifted into rx[0] (rx shifts left) in the clk cycle in which adc_sclk rises; 16 samples per frame, first sample = ADC_data[15].
REQ-023 After the 16th high half-period the FSM SHALL go to HOLD: adc_cs_n=0 and adc_sclk=1 for CLK_DIV cycles.
REQ-024 On leaving HOLD: adc_cs_n SHALL go to 1, ADC_data SHALL take rx, flag SHALL go to 1, and the FSM SHALL go to DONE.
REQ-025 DONE SHALL last FLAG_HOLD cycles; then flag SHALL go to 0 and the FSM SHALL go to IDLE; ADC_data SHALL stay constant until the next frame's HOLD exit.
REQ-026 Frame length from SETUP entry to adc_cs_n rising SHALL be (2 + 32)*CLK_DIV cycles (136 at default).
REQ-027 Changes to ch during a frame SHALL be ignored; the next frame SHALL use the value sampled at the IDLE->SETUP transition.
REQ-028 enable=0 during a frame SHALL NOT abort it; the frame SHALL complete, and no new frame SHALL start while enable=0.
REQ-029 Every output SHALL come from a flop; no combinational path from any input to any output.

Reset
REQ-030 reset_n=0 SHALL immediately force: state IDLE with the GAP counter reloaded, adc_cs_n=1, adc_sclk=1, adc_mosi=0, ADC_data=16'h0000, flag=0, busy=0, ch_lat=0, rx=0.
REQ-031 Reset mid-frame SHALL abort the frame without updating ADC_data or pulsing flag; after release, the first frame SHALL start no earlier than GAP cycles later.

Verification
REQ-032 Default parameters, enable=1, ch=4'd2, MISO model returns 16'hA5C3 -> adc_cs_n low for 136 cycles; MOSI word captured 16'h0800; ADC_data=16'hA5C3; flag high for exactly 4 cycles.
REQ-033 Back-to-back frames with ch stepped 0 -> 2 -> 4 on each flag falling edge, MISO returns 16'h1234 / 16'h5678 / 16'h9ABC -> MOSI words 16'h0000 / 16'h0800 / 16'h1000 in the following frames; ADC_data matches per frame; cs_n high 12 cycles between frames (DONE 4 + GAP 8).
REQ-034 ch toggled every 3 cycles during SHIFT -> MOSI word equals the ch value latched at SETUP entry.
REQ-035 reset_n pulsed low at SCLK edge 7 of a frame -> outputs take reset values in the same cycle; ADC_data stays 0; no flag; next cs_n fall exactly 8 cycles after release.
REQ-036 enable dropped at bit 5 -> the frame completes and flag pulses; adc_cs_n stays high until enable=1; the next frame starts on the first cycle enable is seen high.
REQ-037 CLK_DIV=2, MISO all ones -> ADC_data=16'hFFFF; frame length 68 cycles; SCLK period 4 cycles.
